// File: rtl/cd_tx_ram_pkg.sv
// rtl/cd_tx_ram_pkg.sv - shared block/fragment widths and index-entry layout for the CD frame buffers
package cd_tx_ram_pkg;

    localparam int IDX_LEN_W    = 8;
    localparam int IDX_LEN_LSB  = 0;
    localparam int IDX_FRAG_LSB = IDX_LEN_LSB + IDX_LEN_W;

    // Block size width: bytes per block = 2^s, with 2^i blocks filling a 2^b byte buffer.
    function automatic int cd_s_width(input int b_width, input int i_width);
        return b_width - i_width;
    endfunction

    // Fragment count width: a 256-byte frame spans at most 2^f blocks.
    function automatic int cd_f_width(input int s_width);
        return IDX_LEN_W - s_width;
    endfunction

endpackage

// File: rtl/cd_sdpram.sv
// rtl/cd_sdpram.sv - simple dual-port RAM, one write port, one registered read port
module cd_sdpram #(
    parameter int A_WIDTH = 9,
    parameter int D_WIDTH = 32
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [A_WIDTH-1:0] wr_addr,
    input  logic [D_WIDTH-1:0] wr_data,
    input  logic               rd_en,
    input  logic [A_WIDTH-1:0] rd_addr,
    output logic [D_WIDTH-1:0] rd_data
);

    logic [D_WIDTH-1:0] mem_q [2**A_WIDTH];
    logic [D_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/cd_tx_blk_mask.sv
// rtl/cd_tx_blk_mask.sv - one-hot-range mask of blocks sel..sel+frag, wrapping modulo the block count
module cd_tx_blk_mask #(
    parameter int I_WIDTH = 6,
    parameter int F_WIDTH = 3
) (
    input  logic [I_WIDTH-1:0]      sel,
    input  logic [F_WIDTH-1:0]      frag,
    output logic [(1<<I_WIDTH)-1:0] mask
);

    logic [I_WIDTH-1:0] off;

    always_comb begin
        mask = '0;
        off  = '0;
        for (int i = 0; i < (1 << I_WIDTH); i++) begin
            off     = I_WIDTH'(i) - sel;
            mask[i] = (off <= I_WIDTH'(frag));
        end
    end

endmodule

// File: rtl/cd_tx_ram.sv
// rtl/cd_tx_ram.sv - transmit frame buffer: CPU writes/commits frames, TX engine reads and frees them
// Optional free-block counter output enabled by CD_TX_RAM_FREE_CNT_EN.
module cd_tx_ram
    import cd_tx_ram_pkg::*;
#(
    parameter int I_WIDTH = 6,
    parameter int B_WIDTH = 11
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [31:0]        wr_word,
    input  logic [5:0]         wr_addr,
    input  logic               wr_en,
    input  logic [7:0]         wr_len,
    input  logic               switch,
    output logic               switch_fail,
    output logic [7:0]         rd_byte,
    input  logic [7:0]         rd_addr,
    input  logic               rd_en,
    output logic [7:0]         rd_len,
    output logic               has_data,
    input  logic               rd_done,
    input  logic               rd_done_all,
    output logic [I_WIDTH-1:0] pending_len
`ifdef CD_TX_RAM_FREE_CNT_EN
    ,
    output logic [I_WIDTH:0]   free_blocks
`endif
);

    localparam int S_WIDTH   = cd_s_width(B_WIDTH, I_WIDTH);
    localparam int F_WIDTH   = cd_f_width(S_WIDTH);
    localparam int NBLK      = 1 << I_WIDTH;
    localparam int WA_WIDTH  = B_WIDTH - 2;
    localparam int IDX_WIDTH = F_WIDTH + IDX_LEN_W;

    logic [I_WIDTH-1:0]  wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
    logic [NBLK-1:0]     dirty_q, dirty_d, dirty_free;
    logic                wr_cancel_q, wr_cancel_d;
    logic [I_WIDTH-1:0]  pending_q, pending_d;
    logic                has_data_q, has_data_d;
    logic                switch_fail_q, switch_fail_d;
    logic                wr_pend_q, wr_pend_d;
    logic [31:0]         wr_word_q, wr_word_d;
    logic [WA_WIDTH-1:0] wr_waddr_q, wr_waddr_d;
    logic [1:0]          rd_bsel_q, rd_bsel_d;

    logic [NBLK-1:0]      set_mask, clr_mask;
    logic [F_WIDTH-1:0]   wr_frag, rd_frag;
    logic [I_WIDTH-1:0]   wr_blk;
    logic                 done_ok, commit_ok, wr_ok, wr_hit;
    logic [IDX_WIDTH-1:0] idx_wdata, idx_rdata;
    logic [WA_WIDTH-1:0]  rd_waddr;
    logic [31:0]          rd_word;

`ifdef CD_TX_RAM_FREE_CNT_EN
    logic [I_WIDTH:0]     free_q, free_d;
`endif

    assign wr_frag = wr_len[7:S_WIDTH];
    assign rd_frag = idx_rdata[IDX_FRAG_LSB +: F_WIDTH];

    cd_tx_blk_mask #(.I_WIDTH(I_WIDTH), .F_WIDTH(F_WIDTH)) u_set_mask (
        .sel  (wr_sel_q),
        .frag (wr_frag),
        .mask (set_mask)
    );

    cd_tx_blk_mask #(.I_WIDTH(I_WIDTH), .F_WIDTH(F_WIDTH)) u_clr_mask (
        .sel  (rd_sel_q),
        .frag (rd_frag),
        .mask (clr_mask)
    );

    always_comb begin
        // Blocks freed this cycle are already available to a same-cycle write or commit.
        done_ok    = rd_done & has_data_q & dirty_q[rd_sel_q];
        dirty_free = done_ok ? (dirty_q & ~clr_mask) : dirty_q;
        commit_ok  = switch & ~wr_cancel_q & ~(|(set_mask & dirty_free));
        wr_blk     = wr_sel_q + I_WIDTH'(wr_addr[5:S_WIDTH-2]);
        wr_ok      = wr_en & ~wr_cancel_q & ~dirty_free[wr_blk];
        wr_hit     = wr_en & ~wr_cancel_q & dirty_free[wr_blk];

        idx_wdata = '0;
        idx_wdata[IDX_FRAG_LSB +: F_WIDTH]  = wr_frag;
        idx_wdata[IDX_LEN_LSB +: IDX_LEN_W] = wr_len;

        rd_waddr = {rd_sel_q, {(S_WIDTH-2){1'b0}}} + WA_WIDTH'(rd_addr[7:2]);

        wr_pend_d     = wr_ok;
        wr_word_d     = wr_ok ? wr_word : wr_word_q;
        wr_waddr_d    = wr_ok ? ({wr_sel_q, {(S_WIDTH-2){1'b0}}} + WA_WIDTH'(wr_addr)) : wr_waddr_q;
        wr_cancel_d   = switch ? 1'b0 : (wr_cancel_q | wr_hit);
        dirty_d       = dirty_free | (commit_ok ? set_mask : '0);
        wr_sel_d      = commit_ok ? (wr_sel_q + I_WIDTH'(wr_frag) + I_WIDTH'(1)) : wr_sel_q;
        rd_sel_d      = done_ok ? (rd_sel_q + I_WIDTH'(rd_frag) + I_WIDTH'(1)) : rd_sel_q;
        pending_d     = pending_q + I_WIDTH'(commit_ok) - I_WIDTH'(done_ok);
        // Drop has_data for one cycle after a free so rd_len never shows the stale entry.
        has_data_d    = dirty_q[rd_sel_q] & ~done_ok;
        switch_fail_d = switch & ~commit_ok;
        rd_bsel_d     = rd_en ? rd_addr[1:0] : rd_bsel_q;
`ifdef CD_TX_RAM_FREE_CNT_EN
        free_d = free_q;
        if (commit_ok) free_d = free_d - ((I_WIDTH+1)'(wr_frag) + (I_WIDTH+1)'(1));
        if (done_ok)   free_d = free_d + ((I_WIDTH+1)'(rd_frag) + (I_WIDTH+1)'(1));
`endif

        if (rd_done_all) begin
            wr_pend_d     = 1'b0;
            wr_cancel_d   = 1'b0;
            dirty_d       = '0;
            wr_sel_d      = '0;
            rd_sel_d      = '0;
            pending_d     = '0;
            has_data_d    = 1'b0;
            switch_fail_d = 1'b0;
`ifdef CD_TX_RAM_FREE_CNT_EN
            free_d = (I_WIDTH+1)'(NBLK);
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_sel_q      <= '0;
            rd_sel_q      <= '0;
            dirty_q       <= '0;
            wr_cancel_q   <= 1'b0;
            pending_q     <= '0;
            has_data_q    <= 1'b0;
            switch_fail_q <= 1'b0;
            wr_pend_q     <= 1'b0;
            wr_word_q     <= '0;
            wr_waddr_q    <= '0;
            rd_bsel_q     <= '0;
`ifdef CD_TX_RAM_FREE_CNT_EN
            free_q        <= (I_WIDTH+1)'(NBLK);
`endif
        end else begin
            wr_sel_q      <= wr_sel_d;
            rd_sel_q      <= rd_sel_d;
            dirty_q       <= dirty_d;
            wr_cancel_q   <= wr_cancel_d;
            pending_q     <= pending_d;
            has_data_q    <= has_data_d;
            switch_fail_q <= switch_fail_d;
            wr_pend_q     <= wr_pend_d;
            wr_word_q     <= wr_word_d;
            wr_waddr_q    <= wr_waddr_d;
            rd_bsel_q     <= rd_bsel_d;
`ifdef CD_TX_RAM_FREE_CNT_EN
            free_q        <= free_d;
`endif
        end
    end

    cd_sdpram #(.A_WIDTH(WA_WIDTH), .D_WIDTH(32)) u_data_ram (
        .clk     (clk),
        .wr_en   (wr_pend_q),
        .wr_addr (wr_waddr_q),
        .wr_data (wr_word_q),
        .rd_en   (rd_en),
        .rd_addr (rd_waddr),
        .rd_data (rd_word)
    );

    cd_sdpram #(.A_WIDTH(I_WIDTH), .D_WIDTH(IDX_WIDTH)) u_idx_ram (
        .clk     (clk),
        .wr_en   (commit_ok & ~rd_done_all),
        .wr_addr (wr_sel_q),
        .wr_data (idx_wdata),
        .rd_en   (1'b1),
        .rd_addr (rd_sel_q),
        .rd_data (idx_rdata)
    );

    assign switch_fail = switch_fail_q;
    assign has_data    = has_data_q;
    assign pending_len = pending_q;
    assign rd_len      = has_data_q ? idx_rdata[IDX_LEN_LSB +: IDX_LEN_W] : 8'h00;
    assign rd_byte     = rd_word[{rd_bsel_q, 3'b000} +: 8];
`ifdef CD_TX_RAM_FREE_CNT_EN
    assign free_blocks = free_q;
`endif

endmodule

// File: tb/tb_cd_tx_ram.sv
// tb/tb_cd_tx_ram.sv - self-checking bench for cd_tx_ram (directed corners plus randomized frame traffic)
module tb_cd_tx_ram;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] wr_word;
    logic [5:0]  wr_addr;
    logic        wr_en;
    logic [7:0]  wr_len;
    logic        switch;
    logic        switch_fail;
    logic [7:0]  rd_byte;
    logic [7:0]  rd_addr;
    logic        rd_en;
    logic [7:0]  rd_len;
    logic        has_data;
    logic        rd_done;
    logic        rd_done_all;
    logic [5:0]  pending_len;
`ifdef CD_TX_RAM_FREE_CNT_EN
    logic [6:0]  free_blocks;
`endif

    cd_tx_ram dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_word     (wr_word),
        .wr_addr     (wr_addr),
        .wr_en       (wr_en),
        .wr_len      (wr_len),
        .switch      (switch),
        .switch_fail (switch_fail),
        .rd_byte     (rd_byte),
        .rd_addr     (rd_addr),
        .rd_en       (rd_en),
        .rd_len      (rd_len),
        .has_data    (has_data),
        .rd_done     (rd_done),
        .rd_done_all (rd_done_all),
        .pending_len (pending_len)
`ifdef CD_TX_RAM_FREE_CNT_EN
        ,
        .free_blocks (free_blocks)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put_word(input logic [5:0] a, input logic [31:0] w);
        wr_en = 1'b1; wr_addr = a; wr_word = w;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic do_switch(input logic [7:0] len, output logic fail);
        wr_len = len; switch = 1'b1;
        cyc();
        switch = 1'b0;
        fail = switch_fail;
    endtask

    task automatic do_done();
        rd_done = 1'b1;
        cyc();
        rd_done = 1'b0;
    endtask

    task automatic do_flush();
        rd_done_all = 1'b1;
        cyc();
        rd_done_all = 1'b0;
    endtask

    task automatic rd_one(input logic [7:0] a, output logic [7:0] v);
        rd_en = 1'b1; rd_addr = a;
        cyc();
        rd_en = 1'b0;
        v = rd_byte;
    endtask

    // Transaction-level reference: committed frames in order, the byte image of the buffer.
    typedef struct packed {
        int base;
        int len;
    } frame_t;

    frame_t      fq[$];
    int          m_wsel;
    bit          m_cancel;
    logic [7:0]  m_mem [2048];

    function automatic bit m_busy(input int blk);
        foreach (fq[i]) begin
            if (((blk - fq[i].base + 64) % 64) <= fq[i].len / 32) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void m_reset();
        fq.delete();
        m_wsel   = 0;
        m_cancel = 1'b0;
    endfunction

    function automatic void m_write(input int a, input logic [31:0] w);
        int blk = (m_wsel + a / 8) % 64;
        if (m_cancel) return;
        if (m_busy(blk)) begin
            m_cancel = 1'b1;
        end else begin
            for (int k = 0; k < 4; k++) m_mem[(m_wsel * 32 + a * 4 + k) % 2048] = w[8*k +: 8];
        end
    endfunction

    function automatic bit m_commit(input int len);
        bit fail = m_cancel;
        frame_t f;
        for (int j = 0; j <= len / 32; j++) begin
            if (m_busy((m_wsel + j) % 64)) fail = 1'b1;
        end
        m_cancel = 1'b0;
        if (!fail) begin
            f.base = m_wsel;
            f.len  = len;
            fq.push_back(f);
            m_wsel = (m_wsel + len / 32 + 1) % 64;
        end
        return fail;
    endfunction

    task automatic check_state(input string tag);
        int exp_len = (fq.size() != 0) ? fq[0].len : 0;
        chk({tag, " has_data"}, has_data, (fq.size() != 0) ? 1 : 0);
        chk({tag, " rd_len"}, rd_len, exp_len);
        chk({tag, " pending_len"}, pending_len, fq.size() % 64);
`ifdef CD_TX_RAM_FREE_CNT_EN
        begin
            int used = 0;
            foreach (fq[i]) used += fq[i].len / 32 + 1;
            chk({tag, " free_blocks"}, free_blocks, 64 - used);
        end
`endif
    endtask

    task automatic rand_frame();
        int   len = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255));
        logic f;
        bit   exp_f;
        for (int a = 0; a <= len / 4; a++) begin
            logic [31:0] w = $urandom;
            put_word(a[5:0], w);
            m_write(a, w);
        end
        if ($urandom_range(0, 7) == 0) begin
            int          a = $urandom_range(0, 63);
            logic [31:0] w = $urandom;
            put_word(a[5:0], w);
            m_write(a, w);
        end
        do_switch(len[7:0], f);
        exp_f = m_commit(len);
        chk("rand switch_fail", f, exp_f);
        cyc();
        check_state("rand commit");
    endtask

    task automatic rand_read_done();
        frame_t     f = fq[0];
        int         n = (f.len < 15) ? f.len + 1 : 16;
        logic [7:0] v;
        for (int r = 0; r < n; r++) begin
            int a = (r == 0) ? f.len : int'($urandom_range(0, f.len));
            rd_one(a[7:0], v);
            chk("rand rd_byte", v, m_mem[(f.base * 32 + a) % 2048]);
        end
        do_done();
        void'(fq.pop_front());
        cyc();
        cyc();
        check_state("rand done");
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] exp;
    } rvec_t;

    rvec_t       tab[8];
    logic        f;
    logic [7:0]  v;
    logic [7:0]  exp_b [256];
    int          nfail;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            tab[i].addr = 8'(i);
            tab[i].exp  = 8'(8'h11 * (i + 1));
        end

        reset_n = 1'b0; wr_word = '0; wr_addr = '0; wr_en = 1'b0; wr_len = '0;
        switch = 1'b0; rd_addr = '0; rd_en = 1'b0; rd_done = 1'b0; rd_done_all = 1'b0;
        cyc();
        cyc();
        chk("reset switch_fail", switch_fail, 0);
        chk("reset has_data", has_data, 0);
        chk("reset rd_len", rd_len, 0);
        chk("reset pending_len", pending_len, 0);
`ifdef CD_TX_RAM_FREE_CNT_EN
        chk("reset free_blocks", free_blocks, 64);
`endif
        reset_n = 1'b1;
        cyc();

        // Basic 8-byte frame
        put_word(6'd0, 32'h44332211);
        put_word(6'd1, 32'h88776655);
        do_switch(8'd7, f);
        chk("basic switch_fail", f, 0);
        chk("basic has_data at N+1", has_data, 0);
        cyc();
        chk("basic has_data at N+2", has_data, 1);
        chk("basic rd_len", rd_len, 7);
        chk("basic pending_len", pending_len, 1);
        for (int i = 0; i < 8; i++) begin
            rd_one(tab[i].addr, v);
            chk("basic rd_byte", v, tab[i].exp);
        end
        do_done();
        cyc();
        chk("basic done has_data", has_data, 0);
        chk("basic done pending_len", pending_len, 0);

        // Advance to block 60, then a wrapping 256-byte frame
        do_flush();
        nfail = 0;
        for (int k = 0; k < 8; k++) begin
            do_switch((k < 7) ? 8'd255 : 8'd127, f);
            nfail += int'(f);
            cyc();
            do_done();
            cyc();
        end
        chk("advance fails", nfail, 0);
        for (int a = 0; a < 64; a++) begin
            logic [31:0] w = $urandom;
            for (int k = 0; k < 4; k++) exp_b[a * 4 + k] = w[8*k +: 8];
            put_word(a[5:0], w);
        end
        do_switch(8'd255, f);
        chk("wrap switch_fail", f, 0);
        cyc();
        chk("wrap has_data", has_data, 1);
        chk("wrap rd_len", rd_len, 255);
        for (int a = 0; a < 256; a++) begin
            rd_one(a[7:0], v);
            chk("wrap rd_byte", v, exp_b[a]);
        end
        do_done();
        cyc();
        cyc();
        chk("wrap done pending_len", pending_len, 0);
        chk("wrap done has_data", has_data, 0);
        put_word(6'd0, 32'h000000C3);
        do_switch(8'd0, f);
        cyc();
        chk("after wrap rd_sel=wr_sel has_data", has_data, 1);
        rd_one(8'd0, v);
        chk("after wrap rd_byte", v, 8'hC3);

        // Full buffer
        do_flush();
        nfail = 0;
        for (int k = 0; k < 64; k++) begin
            do_switch(8'd31, f);
            nfail += int'(f);
        end
        chk("fill fails", nfail, 0);
        cyc();
        chk("full pending_len", pending_len, 0);
        chk("full has_data", has_data, 1);
        chk("full rd_len", rd_len, 31);
`ifdef CD_TX_RAM_FREE_CNT_EN
        chk("full free_blocks", free_blocks, 0);
`endif
        put_word(6'd0, 32'h12345678);
        do_switch(8'd31, f);
        chk("full switch_fail pulse", f, 1);
        cyc();
        chk("full switch_fail clears", switch_fail, 0);
        chk("full pending after fail", pending_len, 0);

        // Free and commit in the same cycle on a full buffer
        wr_len = 8'd31; switch = 1'b1; rd_done = 1'b1;
        cyc();
        switch = 1'b0; rd_done = 1'b0;
        chk("simul switch_fail", switch_fail, 0);
        cyc();
        chk("simul pending_len", pending_len, 0);
        chk("simul has_data", has_data, 1);
        chk("simul rd_len", rd_len, 31);
        do_switch(8'd0, f);
        chk("simul still full", f, 1);
        cyc();

        // Reset during a cancelled write
        put_word(6'd0, 32'h55AA55AA);
        #2 reset_n = 1'b0;
        #1;
        chk("async reset switch_fail", switch_fail, 0);
        chk("async reset has_data", has_data, 0);
        chk("async reset rd_len", rd_len, 0);
        chk("async reset pending_len", pending_len, 0);
        cyc();
        reset_n = 1'b1;
        cyc();
        put_word(6'd0, 32'hCAFEF00D);
        do_switch(8'd3, f);
        chk("post-reset switch_fail", f, 0);
        cyc();
        chk("post-reset has_data", has_data, 1);
        chk("post-reset rd_len", rd_len, 3);
        rd_one(8'd0, v);
        chk("post-reset byte0", v, 8'h0D);
        rd_one(8'd3, v);
        chk("post-reset byte3", v, 8'hCA);

        // Flush beats switch/rd_done/wr_en
        do_switch(8'd0, f);
        do_switch(8'd0, f);
        cyc();
        chk("pre-flush pending_len", pending_len, 3);
        rd_done_all = 1'b1; switch = 1'b1; wr_len = 8'd0; rd_done = 1'b1;
        wr_en = 1'b1; wr_addr = 6'd0; wr_word = 32'hDEADBEEF;
        cyc();
        rd_done_all = 1'b0; switch = 1'b0; rd_done = 1'b0; wr_en = 1'b0;
        chk("flush switch_fail", switch_fail, 0);
        chk("flush pending_len", pending_len, 0);
        cyc();
        chk("flush has_data", has_data, 0);
        put_word(6'd0, 32'hA5A51234);
        do_switch(8'd1, f);
        chk("post-flush switch_fail", f, 0);
        cyc();
        chk("post-flush has_data", has_data, 1);
        chk("post-flush rd_len", rd_len, 1);
        rd_one(8'd0, v);
        chk("post-flush byte0", v, 8'h34);
        rd_one(8'd1, v);
        chk("post-flush byte1", v, 8'h12);

        // Randomized traffic against the reference
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        cyc();
        m_reset();
        check_state("rand start");
        for (int it = 0; it < 150; it++) begin
            int pick = $urandom_range(0, 99);
            if (pick < 4) begin
                do_flush();
                m_reset();
                cyc();
                check_state("rand flush");
            end else if (pick < 60 || fq.size() == 0) begin
                rand_frame();
            end else begin
                rand_read_done();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cd_tx_ram.md
Name: cd_tx_ram

Overview:
- Transmit frame buffer between the CPU register interface and the bus transmit engine.
- CPU side writes a frame as 32-bit words into a circular block buffer, then commits it with its length via `switch`.
- TX side reads committed frames byte by byte, in commit order, then frees each with `rd_done`.
- Frames occupy 1..2^F_WIDTH consecutive fixed-size blocks; the buffer is built from two `cd_sdpram` instances (data, index table).

Parameters:
- I_WIDTH, 6, index bit width; 2^6 = 64 blocks / index entries.
- B_WIDTH, 11, buffer bit width; 2^11 = 2048 bytes.
- S_WIDTH, B_WIDTH-I_WIDTH (5), block size width; 32-byte blocks. Derived, not overridden.
- F_WIDTH, 8-S_WIDTH (3), fragment-count width; up to 8 blocks = 256 bytes per frame. Derived.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- wr_word  in  32  CPU data word, little-endian byte order (byte 0 = [7:0])
- wr_addr  in  6  word address within current frame (0..63)
- wr_en  in  1  write strobe, one word per cycle
- wr_len  in  8  frame length minus 1 (0 = 1 byte, 255 = 256 bytes); sampled with switch
- switch  in  1  commit current frame (1-cycle pulse)
- switch_fail  out  1  1-cycle pulse: commit rejected
- rd_byte  out  8  byte read from current frame
- rd_addr  in  8  byte address within current frame
- rd_en  in  1  read strobe
- rd_len  out  8  length field of current frame; valid while has_data=1
- has_data  out  1  current read frame committed and not yet freed
- rd_done  in  1  free current frame, advance to next (1-cycle pulse)
- rd_done_all  in  1  flush: drop all frames and pending writes
- pending_len  out  I_WIDTH  number of committed, unfreed frames

Behaviour:
- Reset (async, and also by synchronous `rd_done_all`):
  - All outputs 0; wr_sel = 0, rd_sel = 0, dirty = 0, wr_cancel = 0.
  - rd_byte is X until the first read.
- Block addressing:
  - Frame base = sel << S_WIDTH; buffer address = base + offset, modulo 2^B_WIDTH.
  - A frame straddling the top of the buffer wraps to block 0.
  - sel arithmetic is modulo 2^I_WIDTH.
- Write path:
  - On wr_en with wr_cancel = 0, compute block index = wr_sel + wr_addr[5:S_WIDTH-2].
  - If that block is dirty: set wr_cancel, drop the word.
  - Otherwise: register the word and address, write the RAM the next cycle.
  - While wr_cancel = 1, further wr_en are ignored.
- Commit (switch asserted in cycle N), with frag = wr_len[7:S_WIDTH]:
  - Fail if wr_cancel = 1, or if any block wr_sel .. wr_sel+frag is dirty. Then switch_fail = 1 in cycle N+1 and no state advances.
  - Otherwise, at edge N+1:
    - Write index entry {frag, wr_len} at wr_sel.
    - Set dirty[wr_sel].
    - Set dirty on continuation blocks wr_sel+1 .. wr_sel+frag so the write check covers them.
    - wr_sel <= wr_sel + frag + 1.
    - pending_len increments.
  - wr_cancel clears at N+1 in both outcomes.
- has_data: registered copy of dirty[rd_sel]; first frame becomes visible in cycle N+2.
- Read path:
  - rd_en in cycle M drives RAM word address (rd_sel << S_WIDTH) + rd_addr, shifted right by 2.
  - rd_addr[1:0] is registered; rd_byte = selected byte of the word, valid in M+1.
  - Reads at any address are permitted; data beyond rd_len is undefined.
- Index table: read continuously at rd_sel, 1-cycle latency. rd_len is valid from the cycle has_data is 1.
- rd_done:
  - With dirty[rd_sel] = 1: clear dirty for rd_sel .. rd_sel+frag, rd_sel <= rd_sel + frag + 1, pending_len decrements.
  - With has_data = 0: ignored.
- Simultaneous events:
  - Successful switch together with rd_done: both applied, pending_len unchanged.
  - rd_done_all wins over switch, rd_done and wr_en in the same cycle; switch_fail stays 0.
- Full buffer: wr_sel may equal rd_sel only when every block is dirty; any further write or commit fails.

Optional Feature:
- Macro: CD_TX_RAM_FREE_CNT_EN.
- Defined: adds output free_blocks [I_WIDTH:0], registered count of non-dirty blocks.
  - Reset value 2^I_WIDTH.
  - Decremented by frag+1 on a successful commit; incremented by frag+1 on rd_done.
  - Both in the same cycle apply the net change.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package: derived widths S_WIDTH/F_WIDTH, and the index-entry layout {frag[F_WIDTH-1:0], len[7:0]} with its field offsets. Shared with cd_rx_ram.
- Storage: reuses existing `cd_sdpram` for data (A_WIDTH = B_WIDTH-2, D_WIDTH = 32) and index (A_WIDTH = I_WIDTH, D_WIDTH = F_WIDTH+8).
- One natural sub-module: `cd_tx_blk_mask`, the combinational dirty-range check/set/clear over sel..sel+frag with wrap.

Test Plan:
- Write words 0x44332211, 0x88776655 at wr_addr 0,1; switch with wr_len = 7 -> has_data = 1 two cycles later, rd_len = 7, pending_len = 1; rd_addr 0..7 returns 0x11..0x88 one cycle after each rd_en.
- Commit a 256-byte frame (wr_len = 255) at wr_sel = 60 -> occupies blocks 60..63, 0..3 (wrap); reads return correct bytes; rd_done -> rd_sel = 4, pending_len = 0.
- Fill all 64 blocks with 32-byte frames, then wr_en at wr_addr 0 and switch -> switch_fail pulses once; pending_len = 0 (6-bit wrap at 64; the free-count variant reads free_blocks = 0).
- Continuing from the full buffer: rd_done and a new commit in the same cycle -> pending_len unchanged, rd_sel and wr_sel each advance by 1.
- rd_done_all asserted together with switch while 3 frames are pending -> has_data = 0, pending_len = 0, switch_fail = 0; a fresh commit then lands at block 0.
- Reset asserted mid-write (wr_cancel = 1) -> all outputs 0, next write/commit succeeds at wr_sel = 0.
